operand_fwd_ctrl: RTL and testbench
===================================

// Module: operand_fwd_ctrl
// PURPOSE
// - Upstream control stage for the EX-stage 32-bit 4-channel operand muxes.
// - Tracks destination registers of instructions in EX, MEM and WB in an internal scoreboard.
// - Produces registered 2-bit operand selects for the next instruction entering EX.
// - Raises a load-use stall when forwarding cannot resolve a hazard.
// - Select code (mux channel): 00=A regfile, 01=B EX/MEM result, 10=C MEM/WB result, 11=D immediate.
// PARAMETERS
// - REG_AW    4   register-address width (2**REG_AW architectural registers; reg 0 hard-wired zero)
// - ZERO_REG  0   register index never forwarded and never a hazard source
// PORTS
// - clk         in   1       rising-edge clock
// - rst_n       in   1       asynchronous, active-low reset
// - id_valid    in   1       ID stage holds a real instruction
// - id_rs       in   REG_AW  source register for operand A
// - id_rt       in   REG_AW  source register for operand B
// - id_uses_rt  in   1       operand B reads id_rt (0: rt not read)
// - id_use_imm  in   1       operand B takes the immediate
// - id_rd       in   REG_AW  destination register
// - id_we       in   1       instruction writes id_rd
// - id_is_load  in   1       instruction is a memory load (result available only at MEM/WB)
// - flush       in   1       kill the ID instruction (branch taken in EX)
// - sel_a       out  2       registered select for operand-A mux, valid during EX cycle
// - sel_b       out  2       registered select for operand-B mux, valid during EX cycle
// - stall       out  1       combinational; freeze PC and IF/ID this cycle
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - EX/MEM/WB scoreboard entries: valid=0, we=0, load=0, rd=0.
//   - sel_a=sel_b=2'b00; stall=0 (derived from empty scoreboard).
//   - Reset asserted mid-operation discards all tracked instructions immediately.
// - Scoreboard: three entries {valid, we, load, rd}, shifting EX->MEM->WB on every clock (no hold).
// - "Live" writer: valid && we && rd!=ZERO_REG.
// - Stall (combinational):
//   - stall = id_valid && !flush && EX.live && EX.load && (EX.rd==id_rs || (id_uses_rt && EX.rd==id_rt)).
// - Forward decision for operand X (rs for A; rt for B when id_uses_rt):
//   - If EX.live && !EX.load && EX.rd==X: code 01 (that instruction is in MEM during our EX).
//   - Else if MEM.live && MEM.rd==X: code 10.
//   - Else: 00.
//   - EX match has priority over MEM match (youngest writer wins).
//   - A load in MEM forwards via 10.
// - sel_b precedence: id_use_imm=1 forces 11 regardless of hazards. id_uses_rt=0 and !id_use_imm gives 00.
// - X==ZERO_REG always yields 00.
// - Clock edge, normal (id_valid && !stall && !flush):
//   - EX entry <= {1, id_we, id_is_load, id_rd}.
//   - sel_a/sel_b <= computed codes.
// - Clock edge, bubble (stall || flush || !id_valid):
//   - EX entry <= all zero; sel_a/sel_b <= 00.
//   - MEM and WB still advance.
// - Stall lasts exactly one cycle per load-use: next cycle the load sits in MEM and resolves via 10.
// - Flush and stall in the same cycle: flush wins, stall=0, bubble inserted.
// - WB entry is tracked for completeness only. Regfile writes in first half-cycle, so WB never forwards.
// - Latency: selects appear exactly one clock after the instruction is presented in ID (unstalled).
// TESTING
// - Reset: rst_n=0 mid-stream with live entries -> sel_a=sel_b=00, stall=0 immediately; first post-reset instr with rs=3 gets 00.
// - EX fwd: I1 rd=5 we=1 (ALU), next I2 rs=5 rt=5 uses_rt=1 -> during I2 EX, sel_a=01, sel_b=01, stall never 1.
// - MEM fwd and priority:
//   - I1 rd=7, I2 unrelated, I3 rs=7 -> sel_a=10.
//   - I1 rd=7, I2 rd=7, I3 rs=7 -> sel_a=01.
// - Load-use: LW rd=4, then ADD rs=4 -> stall=1 for one cycle, bubble (sel 00) into EX; next edge ADD enters EX with sel_a=10.
// - Imm/zero/flush:
//   - rt match with use_imm=1 -> sel_b=11.
//   - rd=0 writer, next rs=0 -> sel_a=00.
//   - Load-use with flush=1 -> stall=0, sel 00 next cycle.

Source files
------------

// File: rtl/operand_fwd_ctrl.sv
// Operand-forwarding control for the EX-stage operand muxes.
// Keeps a 3-deep writer scoreboard (EX/MEM/WB) and issues registered mux selects plus a load-use stall.
module operand_fwd_ctrl #(
    parameter int unsigned REG_AW   = 4,
    parameter int unsigned ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              id_use_imm,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_we,
    input  logic              id_is_load,
    input  logic              flush,
    output logic [1:0]        sel_a,
    output logic [1:0]        sel_b,
    output logic              stall
);

    typedef struct packed {
        logic              valid;
        logic              we;
        logic              load;
        logic [REG_AW-1:0] rd;
    } sb_entry_t;

    typedef enum logic [1:0] {
        SEL_REGFILE = 2'b00,
        SEL_EXMEM   = 2'b01,
        SEL_MEMWB   = 2'b10,
        SEL_IMM     = 2'b11
    } sel_t;

    localparam logic [REG_AW-1:0] ZR = REG_AW'(ZERO_REG);

    sb_entry_t r_ex, r_mem, r_wb;
    sel_t      r_sel_a, r_sel_b;

    logic w_ex_live, w_mem_live;
    logic w_rs_ex_hit, w_rt_ex_hit;
    logic w_accept;
    sel_t w_sel_a, w_sel_b;

    assign w_ex_live  = r_ex.valid  && r_ex.we  && (r_ex.rd  != ZR);
    assign w_mem_live = r_mem.valid && r_mem.we && (r_mem.rd != ZR);

    assign w_rs_ex_hit = w_ex_live && (r_ex.rd == id_rs);
    assign w_rt_ex_hit = w_ex_live && (r_ex.rd == id_rt);

    assign stall = id_valid && !flush && w_ex_live && r_ex.load &&
                   (w_rs_ex_hit || (id_uses_rt && w_rt_ex_hit));

    assign w_accept = id_valid && !stall && !flush;

    // EX hit beats MEM hit: the younger writer holds the current value.
    // A load still in EX never forwards; it is covered by the stall instead.
    always_comb begin
        w_sel_a = SEL_REGFILE;
        if (id_rs == ZR)
            w_sel_a = SEL_REGFILE;
        else if (w_rs_ex_hit && !r_ex.load)
            w_sel_a = SEL_EXMEM;
        else if (w_mem_live && (r_mem.rd == id_rs))
            w_sel_a = SEL_MEMWB;
    end

    always_comb begin
        w_sel_b = SEL_REGFILE;
        if (id_use_imm)
            w_sel_b = SEL_IMM;
        else if (!id_uses_rt || (id_rt == ZR))
            w_sel_b = SEL_REGFILE;
        else if (w_rt_ex_hit && !r_ex.load)
            w_sel_b = SEL_EXMEM;
        else if (w_mem_live && (r_mem.rd == id_rt))
            w_sel_b = SEL_MEMWB;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex    <= '0;
            r_mem   <= '0;
            r_wb    <= '0;
            r_sel_a <= SEL_REGFILE;
            r_sel_b <= SEL_REGFILE;
        end else begin
            r_mem <= r_ex;
            r_wb  <= r_mem;
            if (w_accept) begin
                r_ex    <= '{valid: 1'b1, we: id_we, load: id_is_load, rd: id_rd};
                r_sel_a <= w_sel_a;
                r_sel_b <= w_sel_b;
            end else begin
                r_ex    <= '0;
                r_sel_a <= SEL_REGFILE;
                r_sel_b <= SEL_REGFILE;
            end
        end
    end

    assign sel_a = r_sel_a;
    assign sel_b = r_sel_b;

    // WB never forwards (regfile writes in the first half-cycle); it only mirrors MEM one clock later.
    a_wb_follows_mem: assert property (@(posedge clk) disable iff (!rst_n) r_wb == $past(r_mem));

endmodule

// File: tb/tb_operand_fwd_ctrl.sv
// Scoreboard bench for operand_fwd_ctrl: stimulus pushes hand-computed expectations,
// a monitor pops one per cycle and compares stall (pre-edge) and selects (post-edge).
module tb_operand_fwd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_uses_rt, id_use_imm, id_we, id_is_load, flush;
    logic [3:0] id_rs, id_rt, id_rd;
    logic [1:0] sel_a, sel_b;
    logic       stall;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      name;
        logic       stall;
        logic [1:0] a;
        logic [1:0] b;
    } exp_t;

    exp_t exp_q[$];

    operand_fwd_ctrl #(.REG_AW(4), .ZERO_REG(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .id_use_imm (id_use_imm),
        .id_rd      (id_rd),
        .id_we      (id_we),
        .id_is_load (id_is_load),
        .flush      (flush),
        .sel_a      (sel_a),
        .sel_b      (sel_b),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [1:0] act, input logic [1:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", nm, act, expv);
        end
    endtask

    task automatic drive(input logic v, input int rs, input int rt, input logic urt,
                         input logic uimm, input int rd, input logic we, input logic ld,
                         input logic fl);
        id_valid   = v;
        id_rs      = 4'(rs);
        id_rt      = 4'(rt);
        id_uses_rt = urt;
        id_use_imm = uimm;
        id_rd      = 4'(rd);
        id_we      = we;
        id_is_load = ld;
        flush      = fl;
    endtask

    task automatic issue(input string nm, input logic v, input int rs, input int rt,
                         input logic urt, input logic uimm, input int rd, input logic we,
                         input logic ld, input logic fl, input logic es,
                         input logic [1:0] ea, input logic [1:0] eb);
        exp_t e;
        @(negedge clk);
        drive(v, rs, rt, urt, uimm, rd, we, ld, fl);
        e.name  = nm;
        e.stall = es;
        e.a     = ea;
        e.b     = eb;
        exp_q.push_back(e);
    endtask

    // Monitor: stall sampled mid-cycle, selects sampled just after the following edge.
    initial begin : monitor
        logic s_stall;
        exp_t e;
        forever begin
            @(negedge clk);
            #2 s_stall = stall;
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.name, "_stall"}, {1'b0, s_stall}, {1'b0, e.stall});
                check({e.name, "_sel_a"}, sel_a, e.a);
                check({e.name, "_sel_b"}, sel_b, e.b);
            end
        end
    end

    initial begin : stimulus
        int guard;
        rst_n = 1'b0;
        drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_sel_a", sel_a, 2'b00);
        check("reset_sel_b", sel_b, 2'b00);
        check("reset_stall", {1'b0, stall}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

        //     name          v    rs  rt  urt   uimm  rd  we    ld    fl    stall a      b
        issue("ex_I1",      1'b1, 1,  2,  1'b1, 1'b0, 5,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        issue("ex_I2",      1'b1, 5,  5,  1'b1, 1'b0, 6,  1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01);
        issue("nop_a",      1'b0, 0,  0,  1'b0, 1'b0, 0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        issue("nop_b",      1'b0, 0,  0,  1'b0, 1'b0, 0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        issue("mem_I1",     1'b1, 0,  0,  1'b0, 1'b0, 7,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        issue("mem_I2",     1'b1, 1,  0,  1'b0, 1'b0, 8,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        issue("mem_I3",     1'b1, 7,  8,  1'b1, 1'b0, 9,  1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01);
        issue("pri_J1",     1'b1, 0,  0,  1'b0, 1'b0, 7,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        issue("pri_J2",     1'b1, 9,  0,  1'b0, 1'b0, 7,  1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00);
        issue("pri_J3_imm", 1'b1, 7,  7,  1'b1, 1'b1, 2,  1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b11);
        issue("lu_LW",      1'b1, 0,  0,  1'b0, 1'b0, 4,  1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        issue("lu_ADD_stl", 1'b1, 4,  3,  1'b1, 1'b0, 10, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        issue("lu_ADD_go",  1'b1, 4,  3,  1'b1, 1'b0, 10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00);
        issue("lu_LW2",     1'b1, 0,  0,  1'b0, 1'b0, 11, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        issue("lu_rt_stl",  1'b1, 1,  11, 1'b1, 1'b0, 12, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        issue("lu_rt_go",   1'b1, 1,  11, 1'b1, 1'b0, 12, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10);
        issue("lu_LW3",     1'b1, 0,  0,  1'b0, 1'b0, 13, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        issue("lu_no_rt",   1'b1, 2,  13, 1'b0, 1'b0, 14, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        issue("fl_LW4",     1'b1, 0,  0,  1'b0, 1'b0, 4,  1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        issue("fl_ADD",     1'b1, 4,  0,  1'b0, 1'b0, 10, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        issue("fl_memload", 1'b1, 4,  0,  1'b1, 1'b0, 0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00);
        issue("z_wr",       1'b1, 0,  0,  1'b0, 1'b0, 0,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        issue("z_rd",       1'b1, 0,  0,  1'b1, 1'b0, 3,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        issue("fl_V",       1'b1, 0,  0,  1'b0, 1'b0, 5,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        issue("fl_U",       1'b1, 5,  5,  1'b1, 1'b0, 6,  1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        issue("fl_T",       1'b1, 5,  0,  1'b0, 1'b0, 3,  1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00);
        issue("tail_nop",   1'b0, 0,  0,  1'b0, 1'b0, 0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #2;
        check("drain_queue_left", 2'(exp_q.size()), 2'b00);

        // Mid-stream reset with live entries, including a pending load-use.
        @(negedge clk);
        drive(1'b1, 0, 0, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 3, 0, 1'b0, 1'b0, 3, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("pre_rst_sel_a", sel_a, 2'b01);
        @(negedge clk);
        drive(1'b1, 3, 3, 1'b1, 1'b0, 8, 1'b1, 1'b0, 1'b0);
        #2;
        check("pre_rst_stall", {1'b0, stall}, 2'b01);
        rst_n = 1'b0;
        #1;
        check("rst_now_stall", {1'b0, stall}, 2'b00);
        check("rst_now_sel_a", sel_a, 2'b00);
        check("rst_now_sel_b", sel_b, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        check("post_rst_stall", {1'b0, stall}, 2'b00);
        @(posedge clk);
        #1;
        check("post_rst_sel_a", sel_a, 2'b00);
        check("post_rst_sel_b", sel_b, 2'b00);

        @(negedge clk);
        drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
